// File: rtl/vram_arbiter.sv
// Arbiter sharing one single-port synchronous-read memory between CPU single-word
// accesses and fixed-length VGA read bursts, with a bounded CPU wait during bursts.
module vram_arbiter #(
  parameter int DATA      = 8,
  parameter int ADDR      = 16,
  parameter int BURST_LEN = 8,
  parameter int MAX_WAIT  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [ADDR-1:0] cpu_addr,
  input  logic [DATA-1:0] cpu_wdata,
  output logic            cpu_ack,
  output logic            cpu_rvalid,
  output logic [DATA-1:0] cpu_rdata,
  input  logic            vga_req,
  input  logic [ADDR-1:0] vga_base,
  output logic            vga_ack,
  output logic            vga_rvalid,
  output logic [DATA-1:0] vga_rdata,
  output logic            vga_last,
  output logic [ADDR-1:0] mem_addr,
  output logic            mem_re,
  output logic            mem_we,
  output logic [DATA-1:0] mem_wdata,
  input  logic [DATA-1:0] mem_rdata
);

  localparam int IW = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(BURST_LEN - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [ADDR-1:0] base;
  logic [WW-1:0]   cpu_wait;
  logic            rd_valid;
  logic            rd_vga;
  logic            rd_last;

  logic            cpu_slot;
  logic            vga_slot;
  logic            last_beat;
  logic [ADDR-1:0] vga_addr;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cpu_slot = 1'b0;
    vga_slot = 1'b0;
    if (!rst) begin
      if (state == IDLE) begin
        cpu_slot = cpu_req;
        vga_slot = !cpu_req && vga_req;
      end else begin
        // A CPU that has waited long enough steals this slot; the burst index holds.
        cpu_slot = cpu_req && (cpu_wait == WAIT_MAX);
        vga_slot = !cpu_slot;
      end
    end
  end

  assign vga_addr  = (state == IDLE) ? vga_base : base + ADDR'(idx);
  assign last_beat = vga_slot && (state == BURST) && (idx == LAST_IDX);

  assign cpu_ack   = cpu_slot;
  assign vga_ack   = vga_slot && (state == IDLE);
  assign mem_re    = vga_slot || (cpu_slot && !cpu_we);
  assign mem_we    = cpu_slot && cpu_we;
  assign mem_addr  = cpu_slot ? cpu_addr : (vga_slot ? vga_addr : '0);
  assign mem_wdata = mem_we ? cpu_wdata : '0;

  // Read data arrives one cycle after issue; the registered tag routes it.
  assign cpu_rvalid = !rst && rd_valid && !rd_vga;
  assign vga_rvalid = !rst && rd_valid && rd_vga;
  assign vga_last   = vga_rvalid && rd_last;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign vga_rdata  = vga_rvalid ? mem_rdata : '0;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      base     <= '0;
      cpu_wait <= '0;
      rd_valid <= 1'b0;
      rd_vga   <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= mem_re;
      rd_vga   <= vga_slot;
      rd_last  <= last_beat;

      if (cpu_slot)
        cpu_wait <= '0;
      else if (state == BURST && cpu_req)
        cpu_wait <= cpu_wait + 1'b1;

      case (state)
        IDLE: if (vga_slot) begin
          base  <= vga_base;
          idx   <= IW'(1);
          state <= BURST;
        end
        BURST: if (vga_slot) begin
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios then randomized traffic,
// all compared against a transaction-level model of slot ownership and read returns.
module tb_vram_arbiter;

  localparam int DATA = 8;
  localparam int ADDR = 16;
  localparam int BL   = 8;
  localparam int MW   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            cpu_req, cpu_we;
  logic [ADDR-1:0] cpu_addr;
  logic [DATA-1:0] cpu_wdata;
  logic            cpu_ack, cpu_rvalid;
  logic [DATA-1:0] cpu_rdata;
  logic            vga_req;
  logic [ADDR-1:0] vga_base;
  logic            vga_ack, vga_rvalid, vga_last;
  logic [DATA-1:0] vga_rdata;
  logic [ADDR-1:0] mem_addr;
  logic            mem_re, mem_we;
  logic [DATA-1:0] mem_wdata;
  logic [DATA-1:0] mem_rdata;

  vram_arbiter #(.DATA(DATA), .ADDR(ADDR), .BURST_LEN(BL), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_base(vga_base), .vga_ack(vga_ack),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata), .vga_last(vga_last),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Unwritten locations return a fixed address hash so reads are predictable.
  function automatic logic [7:0] fill(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Memory behind the arbiter: synchronous read, one cycle latency.
  bit [7:0] mem [65536];
  bit       mem_wr [65536];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]    <= mem_wdata;
      mem_wr[mem_addr] <= 1'b1;
    end
    if (mem_re)
      mem_rdata <= mem_wr[mem_addr] ? mem[mem_addr] : fill(mem_addr);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: who owns the memory slot this cycle, and what returns next cycle.
  bit [7:0]  sh_mem [65536];
  bit        sh_wr  [65536];
  bit        m_burst = 1'b0;
  int        m_beat  = 0;
  logic [15:0] m_base = '0;
  int        m_wait  = 0;
  bit        m_rv    = 1'b0;
  bit        m_rvga  = 1'b0;
  bit        m_rlast = 1'b0;
  logic [7:0] m_rdata = '0;
  logic      obs_cack = 1'b0;
  logic      obs_vack = 1'b0;

  function automatic logic [7:0] sh_rd(input logic [15:0] a);
    return sh_wr[a] ? sh_mem[a] : fill(a);
  endfunction

  task automatic sample();
    logic        e_cack, e_vack, e_re, e_we, vga_go;
    logic [15:0] e_addr;
    int          beat;
    @(negedge clk);
    e_cack = 1'b0; e_vack = 1'b0; e_re = 1'b0; e_we = 1'b0; vga_go = 1'b0;
    e_addr = '0; beat = 0;
    if (!rst) begin
      if (!m_burst) begin
        if (cpu_req) e_cack = 1'b1;
        else if (vga_req) begin
          vga_go = 1'b1; e_vack = 1'b1; e_addr = vga_base; beat = 0;
        end
      end else if (cpu_req && m_wait == MW) begin
        e_cack = 1'b1;
      end else begin
        vga_go = 1'b1; beat = m_beat; e_addr = m_base + 16'(m_beat);
      end
      if (e_cack) begin
        e_addr = cpu_addr; e_we = cpu_we; e_re = !cpu_we;
      end
      if (vga_go) e_re = 1'b1;
    end

    check("cpu_ack", 32'(cpu_ack), 32'(e_cack));
    check("vga_ack", 32'(vga_ack), 32'(e_vack));
    check("mem_re", 32'(mem_re), 32'(e_re));
    check("mem_we", 32'(mem_we), 32'(e_we));
    if (e_re || e_we || rst) check("mem_addr", 32'(mem_addr), 32'(e_addr));
    if (e_we) check("mem_wdata", 32'(mem_wdata), 32'(cpu_wdata));
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(!rst && m_rv && !m_rvga));
    check("vga_rvalid", 32'(vga_rvalid), 32'(!rst && m_rv && m_rvga));
    check("vga_last", 32'(vga_last), 32'(!rst && m_rv && m_rvga && m_rlast));
    if (!rst && m_rv && !m_rvga) check("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
    if (!rst && m_rv && m_rvga) check("vga_rdata", 32'(vga_rdata), 32'(m_rdata));
    obs_cack = cpu_ack;
    obs_vack = vga_ack;

    if (rst) begin
      m_burst = 1'b0; m_wait = 0; m_rv = 1'b0;
    end else begin
      m_rv    = e_re;
      m_rvga  = vga_go;
      m_rlast = vga_go && (beat == BL - 1);
      m_rdata = sh_rd(e_addr);
      if (e_we) begin
        sh_mem[e_addr] = cpu_wdata;
        sh_wr[e_addr]  = 1'b1;
      end
      if (e_cack) m_wait = 0;
      else if (m_burst && cpu_req) m_wait++;
      if (vga_go) begin
        if (beat == BL - 1) m_burst = 1'b0;
        else begin
          m_burst = 1'b1;
          m_beat  = beat + 1;
          if (beat == 0) m_base = vga_base;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ack_t, last_t;
    logic [15:0] ea;

    // Reset: outputs forced low even with a request present.
    rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001; cpu_wdata = '0;
    vga_req = 1'b0; vga_base = '0;
    sample();
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    tick(); sample(); tick();
    rst = 1'b0; cpu_req = 1'b0;
    sample();
    check("post_rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("post_rst_vga_rdata", 32'(vga_rdata), 32'd0);

    // 1: idle CPU write.
    tick(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h12AB; cpu_wdata = 8'h5A;
    sample();
    check("t1_ack", 32'(cpu_ack), 32'd1);
    check("t1_we", 32'(mem_we), 32'd1);
    check("t1_addr", 32'(mem_addr), 32'h12AB);
    tick(); cpu_req = 1'b0; cpu_we = 1'b0;
    sample();
    check("t1_no_rvalid", 32'(cpu_rvalid), 32'd0);

    // 2: CPU read back.
    tick(); cpu_req = 1'b1;
    sample();
    check("t2_ack", 32'(cpu_ack), 32'd1);
    tick(); cpu_req = 1'b0;
    sample();
    check("t2_rvalid", 32'(cpu_rvalid), 32'd1);
    check("t2_rdata", 32'(cpu_rdata), 32'h5A);

    // 3: plain burst from 0x4000.
    tick(); vga_req = 1'b1; vga_base = 16'h4000;
    for (int t = 0; t <= 8; t++) begin
      sample();
      if (t == 0) check("t3_vga_ack", 32'(vga_ack), 32'd1);
      if (t < 8) check("t3_addr", 32'(mem_addr), 32'h4000 + 32'(t));
      if (t >= 1) check("t3_rvalid", 32'(vga_rvalid), 32'd1);
      check("t3_last", 32'(vga_last), 32'(t == 8));
      tick();
      if (t == 0) vga_req = 1'b0;
    end

    // 4: CPU read raised at beat 2 steals a slot after MAX_WAIT waiting cycles.
    vga_req = 1'b1; vga_base = 16'h2000;
    ack_t = -1; last_t = -1;
    for (int t = 0; t < 12; t++) begin
      if (t == 2) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h12AB; end
      sample();
      if (cpu_ack) ack_t = t;
      if (vga_last) last_t = t;
      tick();
      if (t == 0) vga_req = 1'b0;
      if (obs_cack) cpu_req = 1'b0;
    end
    check("t4_cpu_ack_cycle", 32'(ack_t), 32'd6);
    check("t4_last_cycle", 32'(last_t), 32'd9);

    // 5: simultaneous requests, burst wraps past 0xFFFF.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h12AB; vga_req = 1'b1; vga_base = 16'hFFFE;
    for (int t = 0; t < 10; t++) begin
      sample();
      if (t == 0) begin
        check("t5_cpu_first", 32'(cpu_ack), 32'd1);
        check("t5_vga_waits", 32'(vga_ack), 32'd0);
      end
      if (t == 1) check("t5_vga_ack", 32'(vga_ack), 32'd1);
      if (t >= 1 && t <= 3) begin
        ea = 16'hFFFE + 16'(t - 1);
        check("t5_wrap_addr", 32'(mem_addr), 32'(ea));
      end
      tick();
      if (t == 0) cpu_req = 1'b0;
      if (t == 1) vga_req = 1'b0;
    end

    // 6: reset during beat 3 abandons the burst.
    vga_req = 1'b1; vga_base = 16'h3000;
    for (int t = 0; t <= 3; t++) begin
      if (t == 3) rst = 1'b1;
      sample();
      if (t == 3) begin
        check("t6_rst_mem_re", 32'(mem_re), 32'd0);
        check("t6_rst_addr", 32'(mem_addr), 32'd0);
        check("t6_rst_rvalid", 32'(vga_rvalid), 32'd0);
      end
      tick();
      if (t == 0) vga_req = 1'b0;
    end
    rst = 1'b0;
    sample();
    check("t6_after_rvalid", 32'(vga_rvalid), 32'd0);
    check("t6_after_mem_re", 32'(mem_re), 32'd0);
    tick(); vga_req = 1'b1; vga_base = 16'h3100;
    sample();
    check("t6_new_ack", 32'(vga_ack), 32'd1);
    check("t6_new_addr", 32'(mem_addr), 32'h3100);
    tick(); vga_req = 1'b0;
    for (int t = 0; t < 10; t++) begin
      sample(); tick();
    end

    // Randomized traffic with requests held until acknowledged.
    for (int i = 0; i < 1500; i++) begin
      if (!cpu_req || obs_cack) begin
        cpu_req   = ($urandom_range(0, 2) == 0);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 16'($urandom_range(16'h11F0, 16'h1230));
        cpu_wdata = 8'($urandom);
      end
      if (!vga_req || obs_vack) begin
        vga_req  = ($urandom_range(0, 6) == 0);
        vga_base = 16'($urandom_range(16'h11E0, 16'h1220));
      end
      rst = ($urandom_range(0, 199) == 0);
      sample();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
